// File: rtl/mem_lane_unit_if.sv
// Pipeline-side and memory-side signals of the MEM-stage byte-lane load/store unit.
// master: the pipeline/memory environment; slave: the unit itself.
interface mem_lane_unit_if;
  // pipeline request
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  // pipeline response
  logic        stall;
  logic        done;
  logic        misalign;
  logic [31:0] rdata;
  // data-memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output req, we, size, sext, addr, wdata, mem_ready, mem_rdata,
    input  stall, done, misalign, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    input  req, we, size, sext, addr, wdata, mem_ready, mem_rdata,
    output stall, done, misalign, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_lane_unit.sv
// MEM-stage byte-lane load/store unit: packs store data into lanes with byte
// enables, extracts and extends load data, and stalls the pipeline until the
// data-memory handshake completes. Illegal (misaligned) accesses complete in one
// cycle without touching memory.
module mem_lane_unit (
  input  logic            clk,
  input  logic            rst_n,
  mem_lane_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [1:0]  lane_q, lane_d;
  logic        done_q, done_d;
  logic        misalign_q, misalign_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        illegal;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] load_ext;
  logic [7:0]  rd_byte [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Split the returned word into its four little-endian byte lanes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_byte[gi] = bus.mem_rdata[8*gi +: 8];
  end

  // Stall whenever an access is being accepted or is waiting on memory.
  assign bus.stall = (state_q == BUSY) || ((state_q == IDLE) && bus.req);

  assign bus.done      = done_q;
  assign bus.misalign  = misalign_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Decode legality, byte enables and lane-replicated store data of the incoming request.
  always_comb begin
    illegal    = 1'b0;
    be_calc    = 4'b0000;
    wdata_calc = bus.wdata;
    case (bus.size)
      2'b00: begin
        be_calc    = 4'b0001 << bus.addr[1:0];
        wdata_calc = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        illegal    = bus.addr[0];
        be_calc    = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{bus.wdata[15:0]}};
      end
      2'b10: begin
        illegal    = (bus.addr[1:0] != 2'b00);
        be_calc    = 4'b1111;
        wdata_calc = bus.wdata;
      end
      default: begin
        illegal    = 1'b1;
      end
    endcase
  end

  // Pick the addressed byte/halfword from the read word and extend it to 32 bits.
  always_comb begin
    byte_sel = rd_byte[lane_q];
    half_sel = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{sext_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  // Next-state and registered-output logic of the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sext_d      = sext_q;
    lane_d      = lane_q;
    done_d      = 1'b0;
    misalign_d  = 1'b0;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          if (illegal) begin
            done_d     = 1'b1;
            misalign_d = 1'b1;
            rdata_d    = 32'h0;
            state_d    = DONE;
          end else begin
            we_d        = bus.we;
            size_d      = bus.size;
            sext_d      = bus.sext;
            lane_d      = bus.addr[1:0];
            mem_req_d   = 1'b1;
            mem_we_d    = bus.we;
            mem_addr_d  = {bus.addr[31:2], 2'b00};
            mem_be_d    = be_calc;
            mem_wdata_d = wdata_calc;
            state_d     = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          done_d    = 1'b1;
          rdata_d   = we_q ? 32'h0 : load_ext;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        // req still shows the instruction just completed, so it is not re-sampled here.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register all state; reset abandons any in-flight memory request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      sext_q      <= 1'b0;
      lane_q      <= 2'b00;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      rdata_q     <= 32'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      lane_q      <= lane_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_lane_unit.sv
// Directed and randomized bench for mem_lane_unit, checked against a
// behavioural model of lane packing, alignment and load extension.
module tb_mem_lane_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_lane_unit_if bus ();

  mem_lane_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (observed running, expected finished)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access, starting and ending #1 after a rising edge with the unit idle.
  task automatic access(input logic a_we, input logic [1:0] a_size, input logic a_sext,
                        input logic [31:0] a_addr, input logic [31:0] a_wdata,
                        input logic [31:0] a_rword, input int waits, input bit hold_req);
    int          nbytes;
    bit          legal;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    longint      mask;
    longint      val;
    int          be_int;

    // reference model
    nbytes = 1 << a_size;
    legal  = (a_size != 2'b11) && ((a_addr % nbytes) == 0);
    be_int = ((1 << nbytes) - 1) << a_addr[1:0];
    exp_be = be_int[3:0];
    if (a_size == 2'b00)      exp_wd = a_wdata[7:0] * 32'h0101_0101;
    else if (a_size == 2'b01) exp_wd = a_wdata[15:0] * 32'h0001_0001;
    else                      exp_wd = a_wdata;
    if (a_we || !legal) begin
      exp_rd = 32'h0;
    end else if (a_size == 2'b10) begin
      exp_rd = a_rword;
    end else begin
      mask = (64'd1 << (8 * nbytes)) - 1;
      val  = (longint'(a_rword) >> (8 * a_addr[1:0])) & mask;
      if (a_sext && val[8*nbytes-1]) val = val | ~mask;
      exp_rd = val[31:0];
    end

    $display("access we=%0d size=%0d sext=%0d addr=%h wdata=%h rword=%h waits=%0d legal=%0d exp_rdata=%h",
             a_we, a_size, a_sext, a_addr, a_wdata, a_rword, waits, legal, exp_rd);

    bus.req       = 1'b1;
    bus.we        = a_we;
    bus.size      = a_size;
    bus.sext      = a_sext;
    bus.addr      = a_addr;
    bus.wdata     = a_wdata;
    bus.mem_ready = 1'b0;
    #1;
    chk("stall_accept", bus.stall, 1);
    @(posedge clk); #1;

    if (!legal) begin
      chk("mis_done", bus.done, 1);
      chk("mis_flag", bus.misalign, 1);
      chk("mis_rdata", bus.rdata, 0);
      chk("mis_mem_req", bus.mem_req, 0);
      chk("mis_stall", bus.stall, 0);
    end else begin
      for (int i = 0; i <= waits; i++) begin
        chk("busy_mem_req", bus.mem_req, 1);
        chk("busy_mem_we", bus.mem_we, a_we);
        chk("busy_mem_addr", bus.mem_addr, {a_addr[31:2], 2'b00});
        chk("busy_mem_be", bus.mem_be, exp_be);
        if (a_we) chk("busy_mem_wdata", bus.mem_wdata, exp_wd);
        chk("busy_done", bus.done, 0);
        bus.mem_ready = (i == waits);
        bus.mem_rdata = (i == waits) ? a_rword : $urandom;
        #1;
        chk("busy_stall", bus.stall, 1);
        @(posedge clk); #1;
      end
      bus.mem_ready = 1'b0;
      bus.mem_rdata = $urandom;
      chk("done", bus.done, 1);
      chk("done_misalign", bus.misalign, 0);
      chk("done_rdata", bus.rdata, exp_rd);
      chk("done_mem_req", bus.mem_req, 0);
      chk("done_stall", bus.stall, 0);
    end

    if (!hold_req) bus.req = 1'b0;
    @(posedge clk); #1;
    chk("after_done", bus.done, 0);
    chk("after_mem_req", bus.mem_req, 0);
    chk("after_misalign", bus.misalign, 0);
  endtask

  // Idle cycles with stray mem_ready pulses, which must be ignored.
  task automatic idle_cycles(input int n);
    bus.req = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.mem_ready = $urandom_range(0, 1);
      bus.mem_rdata = $urandom;
      #1;
      chk("idle_stall", bus.stall, 0);
      @(posedge clk); #1;
      chk("idle_done", bus.done, 0);
      chk("idle_mem_req", bus.mem_req, 0);
    end
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.req       = 1'b0;
    bus.we        = 1'b0;
    bus.size      = 2'b00;
    bus.sext      = 1'b0;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", bus.stall, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_misalign", bus.misalign, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_be", bus.mem_be, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    access(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 1'b0);
    access(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'hBEEF_0001, 0, 1'b0);
    access(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'hBEEF_0001, 0, 1'b0);
    access(1'b1, 2'b00, 1'b0, 32'h0000_0041, 32'h1234_56A5, 32'h0, 3, 1'b0);
    access(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 0, 1'b0);
    access(1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
    access(1'b0, 2'b11, 1'b1, 32'h0000_0100, 32'h0, 32'h0, 0, 1'b0);
    idle_cycles(3);

    // reset while waiting on memory
    $display("reset during BUSY");
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.size = 2'b10;
    bus.addr = 32'h0000_0300;
    @(posedge clk); #1;
    chk("rstmid_busy_req", bus.mem_req, 1);
    rst_n   = 1'b0;
    bus.req = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_mem_req", bus.mem_req, 0);
    chk("rstmid_stall", bus.stall, 0);
    chk("rstmid_done", bus.done, 0);
    chk("rstmid_mem_be", bus.mem_be, 0);
    chk("rstmid_mem_addr", bus.mem_addr, 0);
    rst_n = 1'b1;
    access(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'h1357_9BDF, 1, 1'b0);

    // back-to-back word loads with req held high
    access(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'h1111_2222, 0, 1'b1);
    access(1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0, 32'h3333_4444, 0, 1'b0);

    // randomized accesses
    for (int n = 0; n < 60; n++) begin
      access($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
